// File: rtl/auto_cal_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | auto_cal_pkg : shared types and helpers for the averaging calibrator     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package auto_cal_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      COMMIT = 2'd2
   } cal_state_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int acc_width(input int width, input int avg_log2);
      return width + 1 + avg_log2;
   endfunction

   function automatic int tmo_width(input int timeout);
      return $clog2(timeout) + 1;
   endfunction

   // Clamp a signed value into the unsigned range 0..2^width-1.
   function automatic logic [63:0] sat_u(input logic signed [63:0] value, input int width);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< width) - 64'sd1;
      if (value < 0)
         return 64'd0;
      else if (value > lim)
         return lim;
      else
         return value;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cal_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cal_accum : difference accumulator, sample and timeout counters          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cal_accum
   import auto_cal_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int AVG_LOG2 = 4,
   parameter int TIMEOUT  = 1_000_000,
   localparam int ACC_W   = acc_width(WIDTH, AVG_LOG2),
   localparam int CNT_W   = AVG_LOG2 + 1,
   localparam int TMO_W   = tmo_width(TIMEOUT)
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_start,
   input  logic                    i_active,
   input  logic                    i_abort,
   input  logic                    i_accept,
   input  logic signed [WIDTH:0]   i_diff,
   output logic                    o_done,
   output logic                    o_err,
   output logic signed [WIDTH:0]   o_avg
);

   localparam logic [CNT_W-1:0]        c_last_cnt = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TMO_W-1:0]        c_tmo_lim  = TMO_W'(TIMEOUT - 1);
   localparam logic signed [ACC_W:0]   c_half     = (ACC_W+1)'((1 << AVG_LOG2) >> 1);

   logic signed [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0]        r_cnt;
   logic [TMO_W-1:0]        r_tmo;
   logic signed [ACC_W:0]   w_round;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_tmo <= '0;
      end else if (i_start) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_tmo <= '0;
      end else if (i_active) begin
         if (i_accept) begin
            r_acc <= r_acc + ACC_W'(i_diff);
            r_cnt <= r_cnt + 1'b1;
            r_tmo <= '0;
         end else begin
            r_tmo <= r_tmo + 1'b1;
         end
      end
   end

   // Abort has priority over the final sample; an accepted sample defers the timeout.
   assign o_done  = i_active && i_accept && (r_cnt == c_last_cnt) && !i_abort;
   assign o_err   = i_active && (i_abort || ((r_tmo == c_tmo_lim) && !i_accept));

   assign w_round = (ACC_W+1)'(r_acc) + c_half;
   assign o_avg   = (WIDTH+1)'(w_round >>> AVG_LOG2);

endmodule
`default_nettype wire

// File: rtl/auto_cal_avg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | auto_cal_avg : multi-channel averaged offset calibration and correction  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module auto_cal_avg
   import auto_cal_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NUM_CH   = 4,
   parameter int AVG_LOG2 = 4,
   parameter int TIMEOUT  = 1_000_000,
   localparam int CH_W    = ch_width(NUM_CH)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cal_trig,
   input  logic [CH_W-1:0]   cal_ch,
   input  logic              cal_abort,
   input  logic              cal_switch,
   input  logic              sample_valid,
   input  logic [CH_W-1:0]   sample_ch,
   input  logic [WIDTH-1:0]  xadc_scaled,
   input  logic [WIDTH-1:0]  adc_scaled,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic [WIDTH-1:0]  display_code,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              cal_err
);

   cal_state_t              r_state;
   cal_state_t              w_next;
   logic [CH_W-1:0]         r_cal_ch;
   logic signed [WIDTH:0]   r_offset [NUM_CH];
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;
   logic                    r_out_valid;
   logic [CH_W-1:0]         r_out_ch;
   logic [WIDTH-1:0]        r_code;

   logic                    w_start;
   logic                    w_commit;
   logic                    w_busy_nxt;
   logic                    w_done_nxt;
   logic                    w_err_nxt;
   logic                    w_cal_ch_ok;
   logic                    w_accept;
   logic                    w_acc_done;
   logic                    w_acc_err;
   logic signed [WIDTH:0]   w_diff;
   logic signed [WIDTH:0]   w_avg;
   logic signed [WIDTH:0]   w_off;
   logic signed [WIDTH+1:0] w_sum;
   logic [WIDTH-1:0]        w_corr;

   assign w_diff   = signed'({1'b0, xadc_scaled}) - signed'({1'b0, adc_scaled});
   assign w_accept = sample_valid && (sample_ch == r_cal_ch);

   // Channel indices at or beyond NUM_CH match no entry, giving offset 0 / invalid.
   always_comb begin
      w_off       = '0;
      w_cal_ch_ok = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sample_ch == CH_W'(i))
            w_off = r_offset[i];
         if (cal_ch == CH_W'(i))
            w_cal_ch_ok = 1'b1;
      end
   end

   cal_accum #(
      .WIDTH    (WIDTH),
      .AVG_LOG2 (AVG_LOG2),
      .TIMEOUT  (TIMEOUT)
   ) u_accum (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_start),
      .i_active (r_state == ACCUM),
      .i_abort  (cal_abort),
      .i_accept (w_accept),
      .i_diff   (w_diff),
      .o_done   (w_acc_done),
      .o_err    (w_acc_err),
      .o_avg    (w_avg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_commit   = 1'b0;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (cal_trig) begin
               if (w_cal_ch_ok) begin
                  w_start    = 1'b1;
                  w_next     = ACCUM;
                  w_busy_nxt = 1'b1;
               end else begin
                  w_err_nxt  = 1'b1;
               end
            end
         end
         ACCUM: begin
            w_busy_nxt = 1'b1;
            if (w_acc_err) begin
               w_next     = IDLE;
               w_busy_nxt = 1'b0;
               w_err_nxt  = 1'b1;
            end else if (w_acc_done) begin
               w_next     = COMMIT;
               w_done_nxt = 1'b1;
            end
         end
         COMMIT: begin
            w_commit = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cal_ch <= '0;
         for (int i = 0; i < NUM_CH; i++)
            r_offset[i] <= '0;
      end else begin
         if (w_start)
            r_cal_ch <= cal_ch;
         for (int i = 0; i < NUM_CH; i++)
            if (w_commit && (r_cal_ch == CH_W'(i)))
               r_offset[i] <= w_avg;
      end
   end

   // Sum spans -(2^WIDTH-1)..2^(WIDTH+1)-2, so WIDTH+2 signed bits never wrap.
   assign w_sum  = signed'({2'b00, adc_scaled}) + (WIDTH+2)'(w_off);
   assign w_corr = WIDTH'(sat_u(64'(w_sum), WIDTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_code      <= '0;
      end else begin
         r_out_valid <= sample_valid;
         if (sample_valid) begin
            r_out_ch <= sample_ch;
            r_code   <= cal_switch ? w_corr : adc_scaled;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_ch       = r_out_ch;
   assign display_code = r_code;
   assign cal_busy     = r_busy;
   assign cal_done     = r_done;
   assign cal_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_auto_cal_avg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_auto_cal_avg : scoreboard bench with a behavioural calibration model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_auto_cal_avg;

   localparam int W    = 16;
   localparam int NCH  = 4;
   localparam int AL   = 4;
   localparam int TMO  = 50;
   localparam int NAVG = 1 << AL;
   localparam int MAXV = (1 << W) - 1;

   logic         clk, reset;
   logic         cal_trig, cal_abort, cal_switch, sample_valid;
   logic [1:0]   cal_ch, sample_ch, out_ch;
   logic [W-1:0] xadc_scaled, adc_scaled, display_code;
   logic         out_valid, cal_busy, cal_done, cal_err;

   auto_cal_avg #(
      .WIDTH    (W),
      .NUM_CH   (NCH),
      .AVG_LOG2 (AL),
      .TIMEOUT  (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cal_trig     (cal_trig),
      .cal_ch       (cal_ch),
      .cal_abort    (cal_abort),
      .cal_switch   (cal_switch),
      .sample_valid (sample_valid),
      .sample_ch    (sample_ch),
      .xadc_scaled  (xadc_scaled),
      .adc_scaled   (adc_scaled),
      .out_valid    (out_valid),
      .out_ch       (out_ch),
      .display_code (display_code),
      .cal_busy     (cal_busy),
      .cal_done     (cal_done),
      .cal_err      (cal_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit vld;
      bit busy;
      bit done;
      bit err;
      int ch;
      int code;
   } exp_t;

   exp_t q_exp[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model state: per-channel offsets and the calibration in flight.
   int   m_off [NCH];
   bit   m_on, m_pend;
   int   m_ch, m_sum, m_n, m_idle, m_new;
   bit   g_sw = 1'b1;

   task automatic chk(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   function automatic int fdiv(input int n, input int d);
      int q;
      q = n / d;
      if ((n % d != 0) && (n < 0))
         q = q - 1;
      return q;
   endfunction

   function automatic int clamp(input int v);
      if (v < 0) return 0;
      if (v > MAXV) return MAXV;
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) m_off[i] = 0;
      m_on = 0; m_pend = 0; m_ch = 0; m_sum = 0; m_n = 0; m_idle = 0; m_new = 0;
   endtask

   // One clock of stimulus; the expected response for the following edge is queued.
   task automatic step(input bit trig, input int tch, input bit abort,
                       input bit sv, input int sch, input int x, input int a);
      exp_t e;
      @(negedge clk);
      cal_trig     = trig;
      cal_ch       = tch[1:0];
      cal_abort    = abort;
      cal_switch   = g_sw;
      sample_valid = sv;
      sample_ch    = sch[1:0];
      xadc_scaled  = x[W-1:0];
      adc_scaled   = a[W-1:0];
      e.vld = sv; e.ch = sch; e.code = 0; e.done = 0; e.err = 0;
      if (sv)
         e.code = g_sw ? clamp(a + m_off[sch]) : a;
      if (m_pend) begin
         m_off[m_ch] = m_new;
         m_pend = 0;
      end else if (m_on) begin
         if (abort) begin
            m_on = 0; e.err = 1;
         end else if (sv && sch == m_ch) begin
            m_sum += x - a; m_n++; m_idle = 0;
            if (m_n == NAVG) begin
               m_on = 0; m_pend = 1; e.done = 1;
               m_new = fdiv(m_sum + NAVG / 2, NAVG);
            end
         end else if (m_idle == TMO - 1) begin
            m_on = 0; e.err = 1;
         end else begin
            m_idle++;
         end
      end else if (trig) begin
         if (tch < NCH) begin
            m_on = 1; m_ch = tch; m_sum = 0; m_n = 0; m_idle = 0;
         end else begin
            e.err = 1;
         end
      end
      e.busy = m_on || m_pend;
      q_exp.push_back(e);
   endtask

   task automatic smp(input int ch, input int x, input int a);
      step(0, 0, 0, 1, ch, x, a);
   endtask

   task automatic trig(input int ch);
      step(1, ch, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: one expected record per stimulated cycle, compared after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("cal_busy", int'(cal_busy), int'(e.busy));
            chk("cal_done", int'(cal_done), int'(e.done));
            chk("cal_err", int'(cal_err), int'(e.err));
            chk("out_valid", int'(out_valid), int'(e.vld));
            if (e.vld && out_valid) begin
               chk("display_code", int'(display_code), e.code);
               chk("out_ch", int'(out_ch), e.ch);
            end
         end else if (!reset) begin
            chk("out_valid_unstimulated", int'(out_valid), 0);
         end
      end
   end

   initial begin
      int a, x;
      reset = 1'b1;
      cal_trig = 0; cal_ch = 0; cal_abort = 0; cal_switch = 1; sample_valid = 0;
      sample_ch = 0; xadc_scaled = 0; adc_scaled = 0;
      model_reset();
      #1;
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset display_code", int'(display_code), 0);
      chk("reset cal_busy", int'(cal_busy), 0);
      chk("reset cal_done", int'(cal_done), 0);
      chk("reset cal_err", int'(cal_err), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Plain pass-through with zero offset.
      smp(2, 1000, 1000);
      idle(1);

      // Channel 1 calibration (+3) interleaved with channel 0 traffic.
      trig(1);
      for (int i = 0; i < NAVG; i++) begin
         smp(1, 1203, 1200);
         smp(0, $urandom_range(0, MAXV), $urandom_range(0, MAXV));
      end
      idle(2);
      smp(1, 0, 500);
      smp(0, 0, 500);

      // Rounding of a negative mean: eight -3 and eight -2 on channel 3.
      trig(3);
      for (int i = 0; i < NAVG; i++) begin
         a = $urandom_range(10, 60000);
         smp(3, a - ((i % 2 == 0) ? 3 : 2), a);
      end
      idle(1);
      smp(3, 0, 1);
      g_sw = 0;
      smp(3, 0, 1);
      g_sw = 1;

      // Saturation at both ends.
      trig(0);
      for (int i = 0; i < NAVG; i++) begin
         a = $urandom_range(0, 60000);
         smp(0, a + 10, a);
      end
      idle(1);
      smp(0, 0, 65530);
      trig(2);
      for (int i = 0; i < NAVG; i++) begin
         a = $urandom_range(20, 60000);
         smp(2, a - 10, a);
      end
      smp(2, 0, 5);
      smp(2, 0, 5);

      // Abort after seven samples, then a timeout, then an ignored re-trigger.
      trig(1);
      for (int i = 0; i < 7; i++) smp(1, 2000, 1000);
      step(0, 0, 1, 0, 0, 0, 0);
      smp(1, 0, 500);
      trig(1);
      for (int i = 0; i < TMO + 4; i++) smp(0, 100, 100);
      smp(1, 0, 500);
      trig(2);
      for (int i = 0; i < 5; i++) smp(2, 1020, 1000);
      trig(0);
      for (int i = 0; i < NAVG - 5; i++) smp(2, 1020, 1000);
      idle(1);
      smp(2, 0, 700);

      // Asynchronous reset mid-calibration.
      trig(0);
      for (int i = 0; i < 5; i++) smp(0, 300, 100);
      @(posedge clk);
      #2;
      reset = 1'b1;
      sample_valid = 0; cal_trig = 0; cal_abort = 0;
      #1;
      chk("async reset cal_busy", int'(cal_busy), 0);
      chk("async reset out_valid", int'(out_valid), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < NCH; c++) smp(c, 0, 1234);
      trig(3);
      for (int i = 0; i < NAVG; i++) smp(3, 1100, 1000);
      idle(1);
      smp(3, 0, 1000);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         a = $urandom_range(0, MAXV);
         if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 15);
         else if ($urandom_range(0, 7) == 0) a = MAXV - $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 0) x = clamp(a + $urandom_range(0, 200) - 100);
         else x = $urandom_range(0, MAXV);
         if ($urandom_range(0, 49) == 0) g_sw = ~g_sw;
         step($urandom_range(0, 19) == 0, $urandom_range(0, NCH - 1),
              $urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, NCH - 1), x, a);
      end
      idle(3);
      @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/auto_cal_avg.md
Name: auto_cal_avg

Overview:
- Multi-channel successor to the single-shot offset calibrator.
- On request, averages 2^AVG_LOG2 paired samples of (xadc_scaled - adc_scaled) for one selected channel, then commits a rounded signed offset to that channel's register.
- Every incoming sample is corrected with its channel's offset, saturated, and registered out.
- Sits between the per-channel scaling stage and the display/menu logic.

Parameters:
- WIDTH, 16, bit width of scaled measurements (e.g. mV).
- NUM_CH, 4, number of ADC channels, each with its own offset register.
- AVG_LOG2, 4, log2 of the sample count averaged per calibration (16 samples); legal range 0..8.
- TIMEOUT, 1_000_000, maximum cycles the block waits between accepted calibration samples before aborting.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cal_trig  in  1  one-cycle pulse; starts calibration of channel cal_ch
- cal_ch  in  $clog2(NUM_CH)  channel to calibrate; sampled only when cal_trig is accepted
- cal_abort  in  1  cancels an in-progress calibration
- cal_switch  in  1  1 = corrected output, 0 = raw output
- sample_valid  in  1  sample_ch/xadc_scaled/adc_scaled are valid this cycle
- sample_ch  in  $clog2(NUM_CH)  channel tag of the current sample
- xadc_scaled  in  WIDTH  trusted reference value, scaled
- adc_scaled  in  WIDTH  discrete ADC value, scaled
- out_valid  out  1  display_code/out_ch are valid
- out_ch  out  $clog2(NUM_CH)  channel tag of the output
- display_code  out  WIDTH  raw or corrected value
- cal_busy  out  1  calibration in progress
- cal_done  out  1  one-cycle pulse when an offset is committed
- cal_err  out  1  one-cycle pulse on abort or timeout

Behaviour:
- Reset (asynchronous) clears the following to 0: all offsets, accumulator, sample counter, timeout counter, FSM state (IDLE), and all outputs.
- Datapath latency is exactly 1 cycle. When sample_valid=1 at cycle N, the following are driven at cycle N+1:
  - out_valid=1
  - out_ch = sample_ch
  - display_code = cal_switch ? sat(adc + offset[sample_ch]) : adc_scaled
- sat() clamps the (WIDTH+2)-bit signed sum to the range 0..2^WIDTH-1.
- When sample_valid=0, out_valid=0 and display_code holds its previous value.
- A sample_ch value >= NUM_CH uses offset 0 and is never accumulated.
- Offset registers are signed, WIDTH+1 bits.
- FSM states: IDLE, ACCUM, COMMIT.
- IDLE:
  - cal_trig=1 latches cal_ch and clears the accumulator, sample counter and timeout counter; next state is ACCUM.
  - If cal_ch >= NUM_CH, the block instead pulses cal_err and stays in IDLE.
- ACCUM (cal_busy=1):
  - Each sample with sample_valid=1 and sample_ch equal to the latched channel adds the signed difference (xadc - adc) into the accumulator. The accumulator is WIDTH+1+AVG_LOG2 bits signed, so it never overflows.
  - Each accepted sample increments the sample counter and clears the timeout counter.
  - Every other cycle increments the timeout counter.
  - After the 2^AVG_LOG2-th accepted sample, next state is COMMIT.
  - cal_abort, or the timeout counter reaching TIMEOUT-1, returns the FSM to IDLE with a cal_err pulse; the offset is unchanged.
  - cal_trig is ignored while in ACCUM.
- COMMIT (1 cycle, cal_busy=1):
  - offset[ch] = (acc + 2^(AVG_LOG2-1)) >>> AVG_LOG2, i.e. round half toward +inf; when AVG_LOG2=0 there is no rounding term.
  - Pulses cal_done and returns to IDLE.
- Samples arriving during COMMIT still pass through the datapath and use the old offset. The new offset applies from the cycle after COMMIT.
- Simultaneous cal_abort and final sample: abort wins, nothing is committed.
- A cal_trig arriving in the same cycle as cal_done is ignored.
- The channel being calibrated keeps being corrected with its old offset throughout ACCUM.
- cal_busy, cal_done and cal_err are registered outputs.

Decomposition:
- Shared package auto_cal_pkg holds:
  - cal_state_t enum (IDLE, ACCUM, COMMIT)
  - function sat_u(signed value, width) for the clamp
  - localparams CH_W = $clog2(NUM_CH) and ACC_W = WIDTH+1+AVG_LOG2 (computed in the module, with helper functions in the package)
- One sub-module, cal_accum: the accumulator, sample counter and timeout counter, with start/abort inputs and done/err/avg outputs.
- The top level holds the FSM sequencing, the offset register file and the correction pipeline.

Test Plan:
1. Reset, cal_switch=1, channel 2 sample adc=1000, xadc=1000 -> next cycle: display_code=1000, out_ch=2, out_valid=1, cal_busy=0.
2. cal_trig with cal_ch=1, then 16 channel-1 samples with xadc=1203, adc=1200, interleaved with channel-0 samples -> cal_done exactly 1 cycle after the 16th ch1 sample; then ch1 adc=500 gives 503, ch0 adc=500 gives 500.
3. Rounding: 16 samples with diffs eight of -3 and eight of -2 (acc=-40) -> offset = (-40+8)>>>4 = -2; adc=1 with cal_switch=1 gives 0 (saturated); cal_switch=0 gives raw 1.
4. Saturation high: offset +10 committed, adc=65530 -> 65535; offset -10 committed, adc=5 -> 0.
5. cal_abort after 7 samples, or TIMEOUT (set to 50) elapsing with no channel samples -> cal_err pulse, cal_busy falls, previous offset retained; a second cal_trig during ACCUM is ignored (no restart, sample count continues).
6. Reset asserted mid-ACCUM -> all offsets 0, cal_busy=0 asynchronously, out_valid=0; the following calibration completes normally.
